// File: rtl/map_blit.sv
// rtl/map_blit.sv - full-screen map drawer streaming a stored ROM map into VGA memory
module map_blit #(
  parameter int MAP_W         = 256,
  parameter int MAP_H         = 176,
  parameter int X_ORIGIN      = 31,
  parameter int Y_ORIGIN      = 31,
  parameter int NUM_MAPS      = 4,
  parameter int COLOUR_W      = 6,
  parameter int ROM_LATENCY   = 1,
  parameter int TRANSP_EN     = 0,
  parameter int TRANSP_COLOUR = 0,
  localparam int SEL_W  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  localparam int ADDR_W = (NUM_MAPS * MAP_W * MAP_H > 1) ? $clog2(NUM_MAPS * MAP_W * MAP_H) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                abort,
  input  logic [SEL_W-1:0]    map_sel,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [ADDR_W-1:0]   rom_address,
  output logic [8:0]          x_pos,
  output logic [7:0]          y_pos,
  output logic [COLOUR_W-1:0] colour,
  output logic                VGA_write,
  output logic                busy,
  output logic                draw_done
);

  localparam int MAP_PIX = MAP_W * MAP_H;
  localparam int XW      = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int YW      = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  // Marks the tail stage; everything ahead of it must be empty before finishing.
  localparam logic [ROM_LATENCY-1:0] TAIL_BIT = ROM_LATENCY'(1) << (ROM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [XW-1:0]     fx;
  logic [YW-1:0]     fy;
  logic [SEL_W-1:0]  sel_eff;
  logic [ADDR_W-1:0] base;
  logic              fetch_last;
  logic              pending;
  logic              transp;

  // Tag pipeline: one stage per cycle of ROM latency, tail lines up with rom_q.
  logic [ROM_LATENCY-1:0] vld;
  logic [XW-1:0]          tx [ROM_LATENCY];
  logic [YW-1:0]          ty [ROM_LATENCY];

  // Out-of-range map selects fall back to map 0; base is the map's first word.
  always_comb begin
    sel_eff = map_sel;
    if (int'(map_sel) >= NUM_MAPS) begin
      sel_eff = '0;
    end
    base = ADDR_W'(int'(sel_eff) * MAP_PIX);
  end

  assign fetch_last = (fx == XW'(MAP_W - 1)) && (fy == YW'(MAP_H - 1));
  assign pending    = |(vld & ~TAIL_BIT);

  // Control FSM: address generation, raster counters, busy and done pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rom_address <= '0;
      fx          <= '0;
      fy          <= '0;
      busy        <= 1'b0;
      draw_done   <= 1'b0;
    end else begin
      draw_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state       <= FETCH;
            busy        <= 1'b1;
            rom_address <= base;
            fx          <= '0;
            fy          <= '0;
          end
        end
        FETCH: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (fetch_last) begin
            // Last address stays on the bus while the pipeline empties.
            state <= DRAIN;
          end else begin
            rom_address <= rom_address + ADDR_W'(1);
            if (fx == XW'(MAP_W - 1)) begin
              fx <= '0;
              fy <= fy + YW'(1);
            end else begin
              fx <= fx + XW'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!pending) begin
            // Only the final pixel remains, and it is being written this cycle.
            state     <= IDLE;
            busy      <= 1'b0;
            draw_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Tag shift register; abort drops every in-flight pixel at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tx[i] <= '0;
        ty[i] <= '0;
      end
    end else begin
      if (abort) begin
        vld <= '0;
      end else begin
        vld[0] <= (state == FETCH);
        for (int i = 1; i < ROM_LATENCY; i++) begin
          vld[i] <= vld[i-1];
        end
      end
      tx[0] <= fx;
      ty[0] <= fy;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tx[i] <= tx[i-1];
        ty[i] <= ty[i-1];
      end
    end
  end

  assign transp    = (TRANSP_EN != 0) && (rom_q == COLOUR_W'(TRANSP_COLOUR));
  assign x_pos     = 9'(X_ORIGIN) + 9'(tx[ROM_LATENCY-1]);
  assign y_pos     = 8'(Y_ORIGIN) + 8'(ty[ROM_LATENCY-1]);
  assign colour    = rom_q;
  assign VGA_write = vld[ROM_LATENCY-1] && !transp;

endmodule

// File: tb/tb_map_blit.sv
// tb/tb_map_blit.sv - scoreboard bench for map_blit across three parameter sets
`timescale 1ns/1ps
module tb_map_blit;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  int edges = 0;
  always @(posedge clock) edges <= edges + 1;

  int compared = 0;
  int mismatched = 0;

  localparam int PN [3] = '{45056, 8, 32};
  localparam int PL [3] = '{1, 3, 2};

  // Hand-computed vectors for the 4x2 map, rom word = addr + 20.
  localparam int T1X  [8] = '{31, 32, 33, 34, 31, 32, 33, 34};
  localparam int T1Y  [8] = '{31, 31, 31, 31, 32, 32, 32, 32};
  localparam int T1C2 [8] = '{36, 37, 38, 39, 40, 41, 42, 43};
  localparam int T1C0 [8] = '{20, 21, 22, 23, 24, 25, 26, 27};

  int exp_q  [3][$];
  int done_q [3][$];
  int wr_cnt [3];
  int first0, last0;

  // dut0: default parameters
  logic        start0, abort0;
  logic [1:0]  sel0;
  logic [5:0]  rom_q0 = '0;
  logic [17:0] addr0;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [5:0]  c0;
  logic        we0, busy0, done0;

  // dut1: 4x2 map, latency 3, three maps
  logic        start1, abort1;
  logic [1:0]  sel1;
  logic [5:0]  rom_q1 = '0, r1a = '0, r1b = '0;
  logic [4:0]  addr1;
  logic [8:0]  x1;
  logic [7:0]  y1;
  logic [5:0]  c1;
  logic        we1, busy1, done1;

  // dut2: 8x4 map, latency 2, transparency on colour 0
  logic        start2, abort2;
  logic [1:0]  sel2;
  logic [5:0]  rom_q2 = '0, r2a = '0;
  logic [6:0]  addr2;
  logic [8:0]  x2;
  logic [7:0]  y2;
  logic [5:0]  c2;
  logic        we2, busy2, done2;

  map_blit #(.MAP_W(256), .MAP_H(176), .X_ORIGIN(31), .Y_ORIGIN(31), .NUM_MAPS(4),
             .COLOUR_W(6), .ROM_LATENCY(1), .TRANSP_EN(0), .TRANSP_COLOUR(0)) dut0 (
    .clock(clock), .resetn(resetn), .start(start0), .abort(abort0), .map_sel(sel0),
    .rom_q(rom_q0), .rom_address(addr0), .x_pos(x0), .y_pos(y0), .colour(c0),
    .VGA_write(we0), .busy(busy0), .draw_done(done0));

  map_blit #(.MAP_W(4), .MAP_H(2), .X_ORIGIN(31), .Y_ORIGIN(31), .NUM_MAPS(3),
             .COLOUR_W(6), .ROM_LATENCY(3), .TRANSP_EN(0), .TRANSP_COLOUR(0)) dut1 (
    .clock(clock), .resetn(resetn), .start(start1), .abort(abort1), .map_sel(sel1),
    .rom_q(rom_q1), .rom_address(addr1), .x_pos(x1), .y_pos(y1), .colour(c1),
    .VGA_write(we1), .busy(busy1), .draw_done(done1));

  map_blit #(.MAP_W(8), .MAP_H(4), .X_ORIGIN(31), .Y_ORIGIN(31), .NUM_MAPS(4),
             .COLOUR_W(6), .ROM_LATENCY(2), .TRANSP_EN(1), .TRANSP_COLOUR(0)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2), .abort(abort2), .map_sel(sel2),
    .rom_q(rom_q2), .rom_address(addr2), .x_pos(x2), .y_pos(y2), .colour(c2),
    .VGA_write(we2), .busy(busy2), .draw_done(done2));

  // ROM models with the latency each instance expects
  always @(posedge clock) rom_q0 <= addr0[5:0];
  always @(posedge clock) begin
    r1a    <= 6'(int'(addr1) + 20);
    r1b    <= r1a;
    rom_q1 <= r1b;
  end
  always @(posedge clock) begin
    r2a    <= addr2[0] ? 6'd5 : 6'd0;
    rom_q2 <= r2a;
  end

  function automatic int pack(input int x, input int y, input int c);
    return x * 65536 + y * 256 + c;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Monitor: pops the expected write/done whenever the DUT presents one.
  task automatic mon(input int d, input bit we, input int x, input int y, input int c,
                     input bit dn);
    int e;
    if (we) begin
      wr_cnt[d]++;
      if (d == 0) begin
        if (wr_cnt[0] == 1) first0 = pack(x, y, c);
        last0 = pack(x, y, c);
      end
      compared++;
      if (exp_q[d].size() == 0) begin
        mismatched++;
        $display("FAIL write%0d: unexpected write (%0d,%0d,%0d) at cycle %0d, required none",
                 d, x, y, c, edges + 1);
      end else begin
        e = exp_q[d].pop_front();
        if (e != pack(x, y, c)) begin
          mismatched++;
          $display("FAIL write%0d: got (%0d,%0d,%0d), required (%0d,%0d,%0d)", d, x, y, c,
                   e / 65536, (e / 256) % 256, e % 256);
        end
      end
    end
    if (dn) begin
      compared++;
      if (done_q[d].size() == 0) begin
        mismatched++;
        $display("FAIL done%0d: unexpected draw_done at cycle %0d, required none", d, edges + 1);
      end else begin
        e = done_q[d].pop_front();
        if (e != edges + 1) begin
          mismatched++;
          $display("FAIL done%0d: draw_done at cycle %0d, required cycle %0d", d, edges + 1, e);
        end
      end
    end
  endtask

  always @(negedge clock) mon(0, we0, int'(x0), int'(y0), int'(c0), done0);
  always @(negedge clock) mon(1, we1, int'(x1), int'(y1), int'(c1), done1);
  always @(negedge clock) mon(2, we2, int'(x2), int'(y2), int'(c2), done2);

  function automatic bit get_busy(input int d);
    case (d)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_in(input int d, input bit st, input bit ab, input int sel);
    case (d)
      0: begin start0 = st; abort0 = ab; sel0 = 2'(sel); end
      1: begin start1 = st; abort1 = ab; sel1 = 2'(sel); end
      default: begin start2 = st; abort2 = ab; sel2 = 2'(sel); end
    endcase
  endtask

  // One-cycle start pulse; the expected done cycle is pushed when one is due.
  task automatic kick(input int d, input int sel, input bit ab, input bit want_done);
    @(posedge clock); #1;
    set_in(d, 1'b1, ab, sel);
    if (want_done) done_q[d].push_back(edges + 1 + PN[d] + PL[d] + 1);
    @(posedge clock); #1;
    set_in(d, 1'b0, 1'b0, sel);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (get_busy(d) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (get_busy(d)) begin
      compared++;
      mismatched++;
      $display("FAIL timeout%0d: busy still 1 after %0d cycles, required 0", d, budget);
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic push_frame0();
    for (int k = 0; k < 45056; k++) exp_q[0].push_back(pack(31 + k % 256, 31 + k / 256, k % 64));
  endtask

  task automatic push_frame1(input int map);
    for (int k = 0; k < 8; k++)
      exp_q[1].push_back(pack(T1X[k], T1Y[k], (map == 2) ? T1C2[k] : T1C0[k]));
  endtask

  // Words alternate 0/5 by address parity; colour 0 is transparent.
  task automatic push_frame2(input int map);
    for (int k = 0; k < 32; k++)
      if (((map * 32 + k) % 2) == 1) exp_q[2].push_back(pack(31 + k % 8, 31 + k / 8, 5));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cnt;
    for (int d = 0; d < 3; d++) begin
      wr_cnt[d] = 0;
      set_in(d, 1'b0, 1'b0, 0);
    end
    first0 = -1;
    last0  = -1;
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_addr", int'(addr0), 0);
    chk("reset_x", int'(x0), 31);
    chk("reset_y", int'(y0), 31);
    chk("reset_we", int'(we0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_done", int'(done0), 0);
    resetn = 1'b1;

    // Full default-size draw of map 0
    push_frame0();
    kick(0, 0, 1'b0, 1'b1);
    chk("busy_after_start", int'(busy0), 1);
    wait_idle(0, 50000);
    chk("full_write_count", wr_cnt[0], 45056);
    chk("full_first_write", first0, pack(31, 31, 0));
    chk("full_last_write", last0, pack(286, 206, 63));
    chk("full_done_seen", done_q[0].size(), 0);

    // Small map, map 2, latency 3, with a start while busy
    push_frame1(2);
    kick(1, 2, 1'b0, 1'b1);
    set_in(1, 1'b1, 1'b0, 2);
    @(posedge clock); #1;
    set_in(1, 1'b0, 1'b0, 2);
    wait_idle(1, 100);
    repeat (5) @(posedge clock);
    #1;
    chk("map2_write_count", wr_cnt[1], 8);
    chk("map2_done_seen", done_q[1].size(), 0);
    chk("map2_queue_empty", exp_q[1].size(), 0);

    // Out-of-range select draws map 0
    push_frame1(0);
    kick(1, 3, 1'b0, 1'b1);
    wait_idle(1, 100);
    chk("sel3_write_count", wr_cnt[1], 16);
    chk("sel3_done_seen", done_q[1].size(), 0);

    // start and abort together in IDLE: nothing happens
    kick(1, 1, 1'b1, 1'b0);
    chk("start_abort_busy", int'(busy1), 0);
    repeat (10) @(posedge clock);
    #1;
    chk("start_abort_writes", wr_cnt[1], 16);

    // Transparency: only odd pixels written, done timing unchanged
    push_frame2(1);
    kick(2, 1, 1'b0, 1'b1);
    wait_idle(2, 100);
    chk("transp_write_count", wr_cnt[2], 16);
    chk("transp_done_seen", done_q[2].size(), 0);

    // Abort ten cycles into a draw
    base_cnt = wr_cnt[2];
    push_frame2(0);
    kick(2, 0, 1'b0, 1'b1);
    repeat (9) @(posedge clock);
    #1;
    abort2 = 1'b1;
    @(posedge clock); #1;
    abort2 = 1'b0;
    chk("abort_we", int'(we2), 0);
    chk("abort_busy", int'(busy2), 0);
    chk("abort_writes_before", wr_cnt[2] - base_cnt, 4);
    exp_q[2].delete();
    done_q[2].delete();
    repeat (10) @(posedge clock);
    #1;
    chk("abort_writes_after", wr_cnt[2] - base_cnt, 4);

    // Fresh draw after abort
    base_cnt = wr_cnt[2];
    push_frame2(2);
    kick(2, 2, 1'b0, 1'b1);
    wait_idle(2, 100);
    chk("post_abort_count", wr_cnt[2] - base_cnt, 16);
    chk("post_abort_done", done_q[2].size(), 0);

    // Asynchronous reset mid-draw
    push_frame2(3);
    kick(2, 3, 1'b0, 1'b1);
    repeat (5) @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("areset_addr", int'(addr2), 0);
    chk("areset_x", int'(x2), 31);
    chk("areset_y", int'(y2), 31);
    chk("areset_we", int'(we2), 0);
    chk("areset_busy", int'(busy2), 0);
    chk("areset_done", int'(done2), 0);
    exp_q[2].delete();
    done_q[2].delete();
    base_cnt = wr_cnt[2];
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("areset_no_writes", wr_cnt[2] - base_cnt, 0);

    push_frame2(1);
    kick(2, 1, 1'b0, 1'b1);
    wait_idle(2, 100);
    chk("post_reset_count", wr_cnt[2] - base_cnt, 16);
    chk("post_reset_done", done_q[2].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/map_blit.md
# map_blit

Parametrised full-screen map drawer: on a `start` pulse it streams one of `NUM_MAPS` stored maps, pixel by pixel and in raster order, into VGA memory at a configurable screen origin. The map ROM is external, with a configurable read latency that the block compensates for. The block can skip a transparent colour, can be aborted, and signals completion with a one-cycle `draw_done` pulse. It sits between the game control FSM and the VGA adapter write port.

## Interface
- `MAP_W`, 256, map width in pixels
- `MAP_H`, 176, map height in pixels
- `X_ORIGIN`, 31, screen x of map pixel (0,0)
- `Y_ORIGIN`, 31, screen y of map pixel (0,0)
- `NUM_MAPS`, 4, maps stored back-to-back in ROM (map m at base m·MAP_W·MAP_H)
- `COLOUR_W`, 6, colour width
- `ROM_LATENCY`, 1, ROM read latency in cycles, ≥1
- `TRANSP_EN`, 0, 1 = suppress writes of `TRANSP_COLOUR`
- `TRANSP_COLOUR`, 0, colour treated as transparent
- `SEL_W` = clog2(NUM_MAPS) (min 1); `ADDR_W` = clog2(NUM_MAPS·MAP_W·MAP_H); derived, not overridable
- `clock` in 1: single clock, rising edge
- `resetn` in 1: reset, asynchronous and active-low
- `start` in 1: request draw; sampled only in IDLE
- `abort` in 1: cancel draw in progress
- `map_sel` in SEL_W: map index, latched at accepted `start`
- `rom_q` in COLOUR_W: ROM data, valid ROM_LATENCY cycles after `rom_address`
- `rom_address` out ADDR_W: ROM read address
- `x_pos` out 9, `y_pos` out 8: VGA pixel coordinates
- `colour` out COLOUR_W: VGA pixel data
- `VGA_write` out 1: VGA write enable
- `busy` out 1: high while drawing
- `draw_done` out 1: one-cycle completion pulse

## Operation
- Legal parameters: X_ORIGIN+MAP_W−1 ≤ 511; Y_ORIGIN+MAP_H−1 ≤ 255.
- FSM states:
  - IDLE → FETCH on `start` && !`abort`. The base address is latched at that edge as sel·MAP_W·MAP_H; `map_sel` ≥ NUM_MAPS is treated as map 0.
  - FETCH issues one address per cycle, base+0 … base+N−1, where N = MAP_W·MAP_H. Each address launches a tag (valid, map x, map y) into a ROM_LATENCY-deep shift register. After address N−1: FETCH → DRAIN.
  - DRAIN holds `rom_address` and waits until the pipeline is empty, then → IDLE with `draw_done` = 1 for one cycle.
- Map x/y counters: x wraps at MAP_W−1 to 0 and increments y. Widths are sized from the parameters, with no overflow.
- Pipeline tail aligns with `rom_q`:
  - `x_pos` = X_ORIGIN + tail.x; `y_pos` = Y_ORIGIN + tail.y.
  - `colour` = `rom_q`.
  - `VGA_write` = tail.valid && !(TRANSP_EN && `rom_q` == TRANSP_COLOUR).
- `busy` = state ≠ IDLE. `start` is ignored while busy.
- `abort` in FETCH or DRAIN: next state IDLE, all tag valids cleared, no `draw_done`. `abort` in IDLE wins over `start`.
- Reset values: state IDLE; `rom_address` 0; `x_pos` X_ORIGIN; `y_pos` Y_ORIGIN; `VGA_write` 0; `busy` 0; `draw_done` 0. `colour` follows `rom_q`. Reset mid-draw kills the draw immediately, with no done pulse.

## Timing
- `start` sampled at edge E0. `busy` and `rom_address` = base are visible in cycle E0+1.
- Address k is presented during cycle E0+1+k.
- Pixel k: `VGA_write`/`x_pos`/`y_pos`/`colour` are valid during cycle E0+1+k+ROM_LATENCY.
- Last write in cycle E0+N+ROM_LATENCY. `draw_done` pulses and `busy` falls in cycle E0+N+ROM_LATENCY+1.
- A new `start` is accepted at the edge ending the `draw_done` cycle.
- Sustained throughput: 1 pixel/cycle, no bubbles.
- `abort` sampled at edge Ea: `VGA_write` = 0 from cycle Ea+1.

## Test plan
- Default params, ROM model latency 1, map 0, pattern colour = addr[5:0]:
  - exactly 45056 writes;
  - first write (31,31,0), last write (286,206,(45055 mod 64));
  - `draw_done` single pulse 45058 cycles after the `start` edge.
- MAP_W=4, MAP_H=2, ROM_LATENCY=3, map_sel=2:
  - `rom_address` runs 16…23;
  - writes in raster order (31..34, 31..32) with colours matching ROM[16..23];
  - `draw_done` 12 cycles after `start`.
- TRANSP_EN=1, TRANSP_COLOUR=0, ROM words alternating 0/5: only odd pixels are written, but `draw_done` timing is unchanged.
- Abort: `abort` 10 cycles into a draw → `VGA_write` low the next cycle, `busy` low, no `draw_done`. A fresh `start` then gives a full, correct draw.
- `start` while busy is ignored (write count unchanged). `start` and `abort` in the same IDLE cycle → stays idle. map_sel=3 with NUM_MAPS=3 → draws map 0.
- `resetn` asserted asynchronously mid-draw:
  - all outputs return to their reset values before the next clock edge;
  - no writes occur until the next `start`.
